// File: rtl/gf_reduce81.sv
// gf_reduce81 -- sequential GF(2) reduction of a 2M-1 bit carry-less product
// modulo f(x) = x^M + r(x), using two fixed fold passes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset (discards any in-flight product)
//   in_valid   in_prod is valid
//   in_ready   stage can accept a product (IDLE only)
//   in_prod    unreduced product, bit i = coefficient of x^i
//   out_valid  out_res is valid; held until out_ready
//   out_ready  consumer accepts out_res
//   out_res    reduced residue, degree < M
//   busy       high in any state other than IDLE
module gf_reduce81 #(
    parameter int unsigned     M      = 81,
    parameter logic [M-1:0]    R_POLY = 'h11,
    parameter int unsigned     R_DEG  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-2:0]   in_prod,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [M-1:0]     out_res,
    output logic             busy
);

    localparam int unsigned W = 2 * M - 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FOLD1 = 2'd1;
    localparam logic [1:0] FOLD2 = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]   state_q,     state_d;
    logic [W-1:0] acc_q,       acc_d;
    logic [M-1:0] out_res_q,   out_res_d;
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] fold_acc;

    // One fold: x mod f is congruent to l ^ h*r(x), because x^M == r(x) mod f.
    function automatic logic [W-1:0] fold(input logic [W-1:0] x);
        logic [M-2:0]       h;
        logic [M-1:0]       l;
        logic [M+R_DEG-2:0] hr;
        logic [W-1:0]       res;
        h  = x[W-1:M];
        l  = x[M-1:0];
        hr = '0;
        for (int unsigned j = 0; j <= R_DEG; j++) begin
            if (R_POLY[j]) begin
                hr = hr ^ ({{R_DEG{1'b0}}, h} << j);
            end
        end
        res                = '0;
        res[M+R_DEG-2:0]   = hr;
        res[M-1:0]         = res[M-1:0] ^ l;
        return res;
    endfunction

    always_comb begin
        fold_acc = fold(acc_q);
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_res_d   = out_res_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_prod;
                    state_d = FOLD1;
                end
            end
            FOLD1: begin
                acc_d   = fold_acc;
                state_d = FOLD2;
            end
            FOLD2: begin
                out_res_d   = fold_acc[M-1:0];
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            out_res_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_res_q   <= out_res_d;
            out_valid_q <= out_valid_d;
        end
    end

    // With 2*R_DEG < M the second fold must leave nothing above x^(M-1).
    always_ff @(posedge clk) begin
        if (!rst && state_q == FOLD2) begin
            assert (fold_acc[W-1:M] == '0);
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = out_valid_q;
        out_res   = out_res_q;
    end

endmodule

// File: tb/tb_gf_reduce81.sv
// tb_gf_reduce81 -- directed and randomised checks of gf_reduce81 against a
// bit-serial shift/XOR reduction model and a carry-less multiply model.
module tb_gf_reduce81;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [160:0] in_prod;
    logic         out_valid;
    logic         out_ready;
    logic [80:0]  out_res;
    logic         busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n_sent = 0;
    int n_recv = 0;

    gf_reduce81 #(.M(81), .R_POLY(81'h11), .R_DEG(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [160:0] got, input logic [160:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Long-division style reduction by f = x^81 + x^4 + 1.
    function automatic logic [80:0] ref_reduce(input logic [160:0] p);
        logic [160:0] f;
        logic [160:0] x;
        f      = '0;
        f[81]  = 1'b1;
        f[4]   = 1'b1;
        f[0]   = 1'b1;
        x      = p;
        for (int i = 160; i >= 81; i--) begin
            if (x[i]) x = x ^ (f << (i - 81));
        end
        return x[80:0];
    endfunction

    function automatic logic [160:0] clmul(input logic [80:0] a, input logic [80:0] b);
        logic [160:0] r;
        r = '0;
        for (int i = 0; i < 81; i++) begin
            if (b[i]) r = r ^ ({80'b0, a} << i);
        end
        return r;
    endfunction

    function automatic logic [160:0] rand161();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check({tag, "_ready_to"}, {160'b0, in_ready}, 161'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {160'b0, out_valid}, 161'd1);
    endtask

    // One full transaction with idle cycles before the offer and stall
    // cycles before the consumer accepts.
    task automatic run_txn(input string tag, input logic [160:0] prod,
                           input logic [80:0] exp, input int idle, input int stall);
        repeat (idle) tick();
        wait_ready(tag);
        in_valid = 1'b1;
        in_prod  = prod;
        tick();
        n_sent++;
        in_valid = 1'b0;
        in_prod  = rand161();
        wait_valid(tag);
        repeat (stall) tick();
        check({tag, "_res"}, {80'b0, out_res}, {80'b0, exp});
        out_ready = 1'b1;
        tick();
        if (out_valid === 1'b0) n_recv++;
        out_ready = 1'b0;
        check({tag, "_drop"}, {160'b0, out_valid}, 161'd0);
    endtask

    initial begin
        logic [160:0] p;
        logic [80:0]  a, b, e;
        logic         seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_prod   = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy",   {160'b0, busy},      161'd0);
        check("rst_ready",  {160'b0, in_ready},  161'd1);
        check("rst_valid",  {160'b0, out_valid}, 161'd0);
        check("rst_res",    {80'b0, out_res},    161'd0);

        // T1: x^160 -> x^79 + x^6 + x^2, valid two edges after accept
        p = '0;
        p[160] = 1'b1;
        wait_ready("t1");
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
        check("t1_busy_e0",  {160'b0, busy},      161'd1);
        check("t1_valid_e0", {160'b0, out_valid}, 161'd0);
        tick();
        check("t1_valid_e1", {160'b0, out_valid}, 161'd0);
        tick();
        check("t1_valid_e2", {160'b0, out_valid}, 161'd1);
        e = '0;
        e[79] = 1'b1;
        e[6]  = 1'b1;
        e[2]  = 1'b1;
        check("t1_res", {80'b0, out_res}, {80'b0, e});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("t1_idle", {160'b0, in_ready}, 161'd1);

        // T2: single fold and passthrough
        p = '0;
        p[81] = 1'b1;
        run_txn("t2_x81", p, 81'h11, 0, 0);
        run_txn("t2_pass", 161'h1ABC, 81'h1ABC, 1, 2);

        // T3: all ones
        p = '1;
        run_txn("t3_ones", p, ref_reduce(p), 0, 1);

        // T4: stall in DONE with in_valid asserted
        p = '0;
        p[81] = 1'b1;
        wait_ready("t4");
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        wait_valid("t4");
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_hold_valid", {160'b0, out_valid}, 161'd1);
            check("t4_hold_res",   {80'b0, out_res},    161'h11);
            check("t4_no_ready",   {160'b0, in_ready},  161'd0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("t4_release_idle",  {160'b0, busy},      161'd0);
        check("t4_release_valid", {160'b0, out_valid}, 161'd0);

        // T5a: reset during FOLD1
        p = '0;
        p[160] = 1'b1;
        wait_ready("t5a");
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5a_busy",  {160'b0, busy},      161'd0);
        check("t5a_valid", {160'b0, out_valid}, 161'd0);
        check("t5a_res",   {80'b0, out_res},    161'd0);
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("t5a_stale", {160'b0, seen}, 161'd0);

        // T5b: reset during DONE
        wait_ready("t5b");
        in_valid = 1'b1;
        in_prod  = p;
        tick();
        in_valid = 1'b0;
        wait_valid("t5b");
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5b_busy",  {160'b0, busy},      161'd0);
        check("t5b_valid", {160'b0, out_valid}, 161'd0);
        check("t5b_res",   {80'b0, out_res},    161'd0);
        seen = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("t5b_stale", {160'b0, seen}, 161'd0);

        // T6: random a*b with random gaps
        n_sent = 0;
        n_recv = 0;
        for (int k = 0; k < 1000; k++) begin
            a = {$urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom};
            p = clmul(a, b);
            run_txn("t6", p, ref_reduce(p), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        check("t6_count", n_recv, n_sent);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
